// File: rtl/drum_pkg.sv
// Shared constants and the per-operand truncation record for the DRUM multiplier.
package drum_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned K_DEF     = 6;

  function automatic int unsigned pos_w(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned POS_W = pos_w(WIDTH_DEF);

  typedef struct packed {
    logic [K_DEF-1:0] t;
    logic [POS_W-1:0] s;
    logic             zero;
  } drum_trunc_t;

endpackage

// File: rtl/drum_trunc.sv
// Converts an operand and its leading-one vector into the DRUM truncated
// mantissa t, shift s and zero flag.
module drum_trunc
  import drum_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned K     = K_DEF
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] onehot_i,
  output drum_trunc_t      res_o
);

  logic [POS_W-1:0] pos;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (onehot_i[i]) pos = pos | POS_W'(i);
    end
  end

  always_comb begin
    res_o      = '0;
    shifted    = '0;
    res_o.zero = ~|onehot_i;
    if (!res_o.zero) begin
      if (pos <= POS_W'(K - 1)) begin
        res_o.t = x_i[K-1:0];
      end else begin
        // K bits from the leading one downward; forcing the LSB to 1 unbiases the dropped tail.
        res_o.s = pos - POS_W'(K - 1);
        shifted = x_i >> res_o.s;
        res_o.t = shifted[K-1:0] | K'(1);
      end
    end
  end

endmodule

// File: rtl/lod16.sv
// 16-bit leading-one detector: one-hot flag of the most significant set bit.
module lod16 (
  input  logic [15:0] x_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (x_i[i]) onehot_o = 16'(1) << i;
    end
  end

endmodule

// File: rtl/drum_mul_pipe.sv
// Three-stage DRUM approximate unsigned multiplier with valid/ready streaming
// and per-stage bubble collapsing.
module drum_mul_pipe
  import drum_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned K     = K_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned SH_W = POS_W + 1;

  logic v1_q, v2_q, v3_q;
  logic load1, load2, load3;

  logic [WIDTH-1:0] oh_a_d, oh_b_d;
  logic [WIDTH-1:0] a1_q, b1_q, oha1_q, ohb1_q;

  drum_trunc_t tra_d, trb_d, tra_q, trb_q;

  logic [2*WIDTH-1:0] mul_d, prod_d, product_q;
  logic [SH_W-1:0]    shift_d;

  // A stage may load when empty or when its contents move on this cycle.
  assign load3    = !v3_q || out_ready;
  assign load2    = !v2_q || load3;
  assign load1    = !v1_q || load2;
  assign in_ready = load1;

  lod16 u_lod_a (.x_i(a), .onehot_o(oh_a_d));
  lod16 u_lod_b (.x_i(b), .onehot_o(oh_b_d));

  drum_trunc #(.WIDTH(WIDTH), .K(K)) u_trunc_a (
    .x_i(a1_q), .onehot_i(oha1_q), .res_o(tra_d)
  );
  drum_trunc #(.WIDTH(WIDTH), .K(K)) u_trunc_b (
    .x_i(b1_q), .onehot_i(ohb1_q), .res_o(trb_d)
  );

  always_comb begin
    mul_d   = (2*WIDTH)'(tra_q.t) * (2*WIDTH)'(trb_q.t);
    shift_d = SH_W'(tra_q.s) + SH_W'(trb_q.s);
    prod_d  = (tra_q.zero || trb_q.zero) ? '0 : (mul_d << shift_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      a1_q      <= '0;
      b1_q      <= '0;
      oha1_q    <= '0;
      ohb1_q    <= '0;
      tra_q     <= '0;
      trb_q     <= '0;
      product_q <= '0;
    end else begin
      if (load1) begin
        v1_q   <= in_valid;
        a1_q   <= a;
        b1_q   <= b;
        oha1_q <= oh_a_d;
        ohb1_q <= oh_b_d;
      end
      if (load2) begin
        v2_q  <= v1_q;
        tra_q <= tra_d;
        trb_q <= trb_d;
      end
      if (load3) begin
        v3_q <= v2_q;
        if (v2_q) product_q <= prod_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign product   = product_q;

endmodule
